fire_encoder: RTL and testbench

FIRE_ENCODER -- requirements
Module: fire_encoder

---
 rtl/fire_encoder_if.sv | 23 ++
 rtl/fire_encoder.sv | 142 ++++++++++++++
 tb/tb_fire_encoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fire_encoder_if.sv
// -----------------------------------------------------------------------------
// fire_encoder_if
// Request/response bundle between a Fire-code encoder and its user.
//   start     request to encode (only looked at while the encoder is idle)
//   data_in   K-bit message, data_in[K-1] is the highest-degree coefficient
//   data_out  N-bit systematic codeword {message, parity}
//   done      one-cycle pulse, data_out valid from this cycle on
//   busy      high while an encode is in progress
// master = user side, slave = encoder side.
// -----------------------------------------------------------------------------
interface fire_encoder_if #(
  parameter int N = 64,
  parameter int K = 40
);
  logic         start;
  logic [K-1:0] data_in;
  logic [N-1:0] data_out;
  logic         done;
  logic         busy;

  modport master (output start, data_in, input data_out, done, busy);
  modport slave  (input start, data_in, output data_out, done, busy);
endinterface

// File: rtl/fire_encoder.sv
// -----------------------------------------------------------------------------
// fire_encoder
// Bit-serial systematic encoder for the Fire code generated by
//   g(x) = (x^15+1)(x^9+x^4+1) = x^24+x^19+x^15+x^9+x^4+1  (taps 24'h088211).
// parity = (m(x) * x^24) mod g(x); data_out = {message, parity}.
// One message bit is folded into the parity LFSR per clock, MSB first, so an
// encode takes K SHIFT cycles plus one DONE cycle.
//
// Ports
//   clk    rising-edge system clock
//   reset  asynchronous, active-low reset
//   bus    fire_encoder_if.slave: start, data_in in; data_out, done, busy out
//
// Parameters
//   N  codeword length, K message length; N-K must equal 24 (degree of g).
// -----------------------------------------------------------------------------
module fire_encoder #(
  parameter int N = 64,
  parameter int K = 40
) (
  input  logic           clk,
  input  logic           reset,
  fire_encoder_if.slave  bus
);

  localparam int          P   = N - K;
  localparam int          CW  = $clog2(K);
  localparam logic [P-1:0] TAP = P'(24'h088211);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [K-1:0]   msg;
  logic [P-1:0]   lfsr;
  logic [P-1:0]   lfsr_next;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   data_out_q;
  logic           fb;

  logic           load;
  logic           step;
  logic           finish;
  logic           busy_c;
  logic           done_c;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        step   = 1'b1;
        // The counter never wraps: the bit at index 0 is the last one and
        // consuming it is what ends the encode.
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;

  // ---------------------------------------------------------------------------
  // Parity LFSR feedback
  // ---------------------------------------------------------------------------
  // The message is held whole (it is also the top of the codeword) and the
  // counter selects the current bit, which gives MSB-first order without a
  // second shifting copy.
  always_comb begin
    fb        = msg[cnt] ^ lfsr[P-1];
    lfsr_next = {lfsr[P-2:0], 1'b0} ^ (fb ? TAP : '0);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the message register is reset along with the rest of the datapath
  // so an aborted encode leaves no trace of the old message behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg        <= '0;
      lfsr       <= '0;
      cnt        <= '0;
      data_out_q <= '0;
    end else if (load) begin
      msg  <= bus.data_in;
      lfsr <= '0;
      cnt  <= CW'(K - 1);
    end else if (step) begin
      lfsr <= lfsr_next;
      if (finish) begin
        // Codeword is captured only here, so data_out stays put for the
        // whole of the next encode.
        data_out_q <= {msg, lfsr_next};
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_fire_encoder.sv
// -----------------------------------------------------------------------------
// tb_fire_encoder
// Scoreboard bench for fire_encoder. Stimulus pushes the expected codeword
// when the start edge is issued; a monitor pops and compares on every done.
// Directed codewords are hand-computed; random messages use a reference
// long division by g(x).
// -----------------------------------------------------------------------------
module tb_fire_encoder;

  localparam int N = 64;
  localparam int K = 40;
  localparam logic [63:0] G_POLY = 64'h0000_0000_0108_8211;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fire_encoder_if #(.N(N), .K(K)) bus ();

  fire_encoder #(.N(N), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks     = 0;
  int          errors     = 0;
  int          done_count = 0;
  longint      cycle      = 0;
  logic [63:0] exp_q[$];
  longint      done_cycles[$];
  logic [63:0] last_cw    = '0;
  logic        done_prev  = 1'b0;

  typedef struct {
    logic [39:0] msg;
    logic [63:0] cw;
  } vec_t;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference remainder of a polynomial modulo g(x), plain long division.
  function automatic logic [23:0] mod_g(input logic [63:0] v);
    logic [63:0] r;
    r = v;
    for (int i = 63; i >= 24; i--)
      if (r[i]) r = r ^ (G_POLY << (i - 24));
    return r[23:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      last_cw   = '0;
      done_prev = 1'b0;
    end else begin
      if (bus.done) begin
        check("done_single_cycle", done_prev, 1'b0);
        check("busy_low_in_done", bus.busy, 1'b0);
        done_count++;
        done_cycles.push_back(cycle);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          check("codeword", bus.data_out, exp_q.pop_front());
          check("remainder", 64'(mod_g(bus.data_out)), 64'h0);
        end
        last_cw = bus.data_out;
      end else begin
        check("data_out_hold", bus.data_out, last_cw);
      end
      done_prev = bus.done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, with the DUT idle)
  // ---------------------------------------------------------------------------
  task automatic encode(input logic [39:0] msg, input logic [63:0] cw, output int lat);
    int n;
    bit busy_ok;
    bus.start   = 1'b1;
    bus.data_in = msg;
    @(posedge clk);
    exp_q.push_back(cw);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = ~msg;
    n       = 0;
    busy_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!bus.done) fail_now("encode_timeout");
    check("busy_while_shifting", busy_ok, 1'b1);
    lat = n;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) fail_now(name);
  endtask

  // Hand-computed: parity of x^i is x^(24+i) mod g, XOR-combined.
  vec_t hand[6] = '{
    '{40'h00_0000_0000, 64'h0000_0000_0000_0000},
    '{40'h00_0000_0001, 64'h0000_0000_0108_8211},
    '{40'h00_0000_0002, 64'h0000_0000_0211_0422},
    '{40'h00_0000_0020, 64'h0000_0000_2018_C031},
    '{40'h00_0000_0021, 64'h0000_0000_2110_4220},
    '{40'h00_0000_003F, 64'h0000_0000_3FEF_7FDE}
  };

  initial begin
    int lat;
    int dc;
    int di;
    int n;
    logic [39:0] m;

    bus.start   = 1'b0;
    bus.data_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_data_out", bus.data_out, 64'h0);
    check("reset_done", bus.done, 1'b0);
    check("reset_busy", bus.busy, 1'b0);

    // Release and start in the same cycle: first edge after release must take it.
    @(negedge clk);
    reset = 1'b1;
    encode(hand[0].msg, hand[0].cw, lat);
    // done is seen in the cycle that ends at the 41st edge after start.
    check("latency_first", lat, K);

    // Directed vectors
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      encode(hand[i].msg, hand[i].cw, lat);
      check("latency_directed", lat, K);
    end

    // Second start pulse during SHIFT cycle 10 is ignored.
    @(negedge clk);
    dc          = done_count;
    bus.start   = 1'b1;
    bus.data_in = hand[4].msg;
    @(posedge clk);
    exp_q.push_back(hand[4].cw);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = hand[5].msg;
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored_start_timeout");
    repeat (60) @(negedge clk);
    check("one_done_pulse", done_count - dc, 1);

    // Reset mid-SHIFT aborts the encode.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = hand[3].msg;
    @(posedge clk);
    exp_q.push_back(hand[3].cw);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_data_out", bus.data_out, 64'h0);
    check("abort_done", bus.done, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dc = done_count;
    repeat (60) @(negedge clk);
    check("no_done_after_abort", done_count - dc, 0);
    @(negedge clk);
    encode(hand[5].msg, hand[5].cw, lat);
    check("latency_after_abort", lat, K);

    // start held high across three encodes.
    @(negedge clk);
    di          = done_cycles.size();
    bus.start   = 1'b1;
    bus.data_in = hand[1].msg;
    @(posedge clk);
    exp_q.push_back(hand[1].cw);
    @(negedge clk);
    bus.data_in = hand[2].msg;
    exp_q.push_back(hand[2].cw);
    wait_done("b2b_first_timeout");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.data_in = hand[4].msg;
    exp_q.push_back(hand[4].cw);
    n = 0;
    while (bus.done && n < 5) begin
      @(negedge clk);
      n++;
    end
    wait_done("b2b_second_timeout");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    wait_done("b2b_third_timeout");
    @(negedge clk);
    check("b2b_done_count", done_cycles.size() - di, 3);
    if (done_cycles.size() - di == 3) begin
      check("b2b_spacing_1", 64'(done_cycles[di+1] - done_cycles[di]), 64'd42);
      check("b2b_spacing_2", 64'(done_cycles[di+2] - done_cycles[di+1]), 64'd42);
    end

    // Random messages against the reference division.
    for (int i = 0; i < 1000; i++) begin
      m = {8'($urandom), 32'($urandom)};
      @(negedge clk);
      encode(m, {m, mod_g({m, 24'h0})}, lat);
      check("latency_random", lat, K);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
